// File: rtl/usb_midi_audio_synth_irq_capture.sv
// ---------------------------------------------------------------------------
// usb_midi_audio_synth_irq_capture
//
// Purpose:
//   Interrupt capture and aggregation stage. It turns level IRQ lines into
//   edge-captured pending bits. It keeps a per-source mask, per-source
//   overrun flags and saturating per-source event counters. It drives one
//   combined, registered interrupt and exposes all state through a 16-bit
//   Avalon-MM slave with registered read data and no wait states.
//
// Register map (word addresses):
//   0       PENDING   W1C
//   1       MASK      RW
//   2       STATUS    RO   PENDING & MASK
//   3       OVERRUN   W1C
//   4       RAW       RO   current irq_in
//   5+i     COUNT[i]  RO   any write clears it (i < N_SRC)
//   others  read 0, writes ignored
//
// Ports:
//   clk         system clock, sole clock domain
//   reset       synchronous, active-high reset
//   irq_in      level IRQ inputs, synchronous to clk
//   address     Avalon word address
//   chipselect  Avalon select
//   write_n     Avalon write strobe, active low
//   writedata   Avalon write data
//   readdata    registered read data, one cycle latency
//   irq         combined registered interrupt to the processor
// ---------------------------------------------------------------------------
module usb_midi_audio_synth_irq_capture #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_SRC-1:0]  irq_in,
    input  logic [3:0]        address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // State registers
    logic [N_SRC-1:0] irq_dly_q;
    logic [N_SRC-1:0] pend_q,  pend_d;
    logic [N_SRC-1:0] mask_q,  mask_d;
    logic [N_SRC-1:0] ovr_q,   ovr_d;
    logic [CNT_W-1:0] cnt_q [N_SRC];
    logic [CNT_W-1:0] cnt_d [N_SRC];
    logic [15:0]      rdata_q, rdata_d;
    logic             irq_q,   irq_d;

    // Decoded bus strobes and edge vector
    logic             wr_s;
    logic             wr_pend_s;
    logic             wr_mask_s;
    logic             wr_ovr_s;
    logic [N_SRC-1:0] edge_s;
    logic [N_SRC-1:0] clr_pend_s;
    logic [N_SRC-1:0] clr_ovr_s;

    assign wr_s      = chipselect & ~write_n;
    assign wr_pend_s = wr_s & (address == 4'd0);
    assign wr_mask_s = wr_s & (address == 4'd1);
    assign wr_ovr_s  = wr_s & (address == 4'd3);

    // The delay register resets to ones, so a line high at reset is no edge.
    assign edge_s = irq_in & ~irq_dly_q;

    // Bitmap next-state: pending, overrun and mask (a set beats a W1C).
    always_comb begin
        clr_pend_s = {N_SRC{1'b0}};
        clr_ovr_s  = {N_SRC{1'b0}};
        if (wr_pend_s) begin
            clr_pend_s = writedata[N_SRC-1:0];
        end else begin
            clr_pend_s = {N_SRC{1'b0}};
        end
        if (wr_ovr_s) begin
            clr_ovr_s = writedata[N_SRC-1:0];
        end else begin
            clr_ovr_s = {N_SRC{1'b0}};
        end
        pend_d = edge_s | (pend_q & ~clr_pend_s);
        // Overrun only when the old pending bit survives this cycle.
        ovr_d  = (edge_s & pend_q & ~clr_pend_s) | (ovr_q & ~clr_ovr_s);
        if (wr_mask_s) begin
            mask_d = writedata[N_SRC-1:0];
        end else begin
            mask_d = mask_q;
        end
        // irq follows the next-state values so it has one cycle of latency.
        irq_d = |(pend_d & mask_d);
    end

    // Event counter next-state: saturating increment, write clears.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            cnt_d[i] = cnt_q[i];
            if (wr_s && (address == 4'(i + 5))) begin
                // A clear together with an edge leaves a count of one.
                if (edge_s[i]) begin
                    cnt_d[i] = CNT_ONE;
                end else begin
                    cnt_d[i] = {CNT_W{1'b0}};
                end
            end else if (edge_s[i] && (cnt_q[i] != CNT_MAX)) begin
                cnt_d[i] = cnt_q[i] + CNT_ONE;
            end else begin
                cnt_d[i] = cnt_q[i];
            end
        end
    end

    // Read mux from current (pre-write) state, registered every cycle.
    always_comb begin
        rdata_d = 16'h0000;
        case (address)
            4'd0: rdata_d[N_SRC-1:0] = pend_q;
            4'd1: rdata_d[N_SRC-1:0] = mask_q;
            4'd2: rdata_d[N_SRC-1:0] = pend_q & mask_q;
            4'd3: rdata_d[N_SRC-1:0] = ovr_q;
            4'd4: rdata_d[N_SRC-1:0] = irq_in;
            default: begin
                for (int i = 0; i < N_SRC; i++) begin
                    if (address == 4'(i + 5)) begin
                        rdata_d[CNT_W-1:0] = cnt_q[i];
                    end else begin
                        rdata_d = rdata_d;
                    end
                end
            end
        endcase
    end

    // State update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            irq_dly_q <= {N_SRC{1'b1}};
            pend_q    <= {N_SRC{1'b0}};
            mask_q    <= {N_SRC{1'b0}};
            ovr_q     <= {N_SRC{1'b0}};
            rdata_q   <= 16'h0000;
            irq_q     <= 1'b0;
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= {CNT_W{1'b0}};
            end
        end else begin
            irq_dly_q <= irq_in;
            pend_q    <= pend_d;
            mask_q    <= mask_d;
            ovr_q     <= ovr_d;
            rdata_q   <= rdata_d;
            irq_q     <= irq_d;
            for (int i = 0; i < N_SRC; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    assign readdata = rdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_usb_midi_audio_synth_irq_capture.sv
// Directed bench for usb_midi_audio_synth_irq_capture (N_SRC=4, CNT_W=8).
module tb_usb_midi_audio_synth_irq_capture;

    logic        clk;
    logic        reset;
    logic [3:0]  irq_in;
    logic [3:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;
    logic        irq;

    int n_total = 0;
    int n_bad   = 0;
    logic [15:0] rd;

    usb_midi_audio_synth_irq_capture #(.N_SRC(4), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .irq        (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
        end
    endtask

    // One clock: inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_read(input logic [3:0] a, output logic [15:0] d);
        address    = a;
        chipselect = 1'b1;
        write_n    = 1'b1;
        tick();
        chipselect = 1'b0;
        d = readdata;
    endtask

    // Returns the readdata captured in the write cycle (pre-write value).
    task automatic bus_write(input logic [3:0] a, input logic [15:0] wd, output logic [15:0] d);
        address    = a;
        writedata  = wd;
        chipselect = 1'b1;
        write_n    = 1'b0;
        tick();
        chipselect = 1'b0;
        write_n    = 1'b1;
        d = readdata;
    endtask

    initial begin
        reset = 1'b1; irq_in = 4'b0001; address = 4'd0;
        chipselect = 1'b0; write_n = 1'b1; writedata = 16'h0000;
        tick(); tick();
        check_eq("reset_readdata", readdata, 16'h0000);
        check_eq("reset_irq", {15'h0000, irq}, 16'h0000);
        reset = 1'b0;
        tick(); tick();

        // T1: line high through reset gives no edge; a fresh rise does.
        bus_read(4'd0, rd);
        check_eq("t1_no_edge_at_reset", rd, 16'h0000);
        irq_in = 4'b0000; tick();
        irq_in = 4'b0001; tick();
        check_eq("t1_irq_masked", {15'h0000, irq}, 16'h0000);
        bus_read(4'd0, rd);
        check_eq("t1_pending", rd, 16'h0001);

        // T2: unmask raises irq, W1C drops it.
        bus_write(4'd1, 16'h0001, rd);
        check_eq("t2_irq_unmask", {15'h0000, irq}, 16'h0001);
        bus_write(4'd0, 16'h0001, rd);
        check_eq("t2_irq_w1c", {15'h0000, irq}, 16'h0000);
        bus_read(4'd0, rd);
        check_eq("t2_pending_clr", rd, 16'h0000);
        bus_read(4'd2, rd);
        check_eq("t2_status", rd, 16'h0000);
        bus_read(4'd1, rd);
        check_eq("t2_mask", rd, 16'h0001);

        // T3: two edges on source 1 without clearing.
        irq_in = 4'b0011; tick();
        irq_in = 4'b0001; tick();
        irq_in = 4'b0011; tick();
        irq_in = 4'b0001; tick();
        bus_read(4'd0, rd);
        check_eq("t3_pending", rd, 16'h0002);
        bus_read(4'd3, rd);
        check_eq("t3_overrun", rd, 16'h0002);
        bus_read(4'd6, rd);
        check_eq("t3_count1", rd, 16'h0002);
        check_eq("t3_irq_masked", {15'h0000, irq}, 16'h0000);
        bus_write(4'd3, 16'h0002, rd);
        bus_read(4'd3, rd);
        check_eq("t3_overrun_clr", rd, 16'h0000);

        // T4: edge vs W1C on pending bit 2, edge vs clear on COUNT[2].
        irq_in = 4'b0101; tick();
        irq_in = 4'b0001; tick();
        irq_in = 4'b0101;
        bus_write(4'd0, 16'h0004, rd);
        bus_read(4'd0, rd);
        check_eq("t4_pend_set_wins", rd, 16'h0006);
        bus_read(4'd3, rd);
        check_eq("t4_no_ovr_when_clr", rd, 16'h0000);
        bus_read(4'd7, rd);
        check_eq("t4_count2_two", rd, 16'h0002);
        irq_in = 4'b0001; tick();
        irq_in = 4'b0101;
        bus_write(4'd7, 16'h0000, rd);
        bus_read(4'd7, rd);
        check_eq("t4_count_clr_edge", rd, 16'h0001);
        bus_read(4'd3, rd);
        check_eq("t4_overrun2", rd, 16'h0004);

        // T5: 300 pulses saturate COUNT[3].
        for (int k = 0; k < 300; k++) begin
            irq_in = 4'b1101; tick();
            irq_in = 4'b0101; tick();
        end
        bus_read(4'd8, rd);
        check_eq("t5_saturate", rd, 16'h00FF);
        bus_write(4'd8, 16'h1234, rd);
        check_eq("t5_read_prewrite", rd, 16'h00FF);
        bus_read(4'd8, rd);
        check_eq("t5_count_clr", rd, 16'h0000);
        bus_read(4'd4, rd);
        check_eq("t5_raw", rd, 16'h0005);
        bus_read(4'd15, rd);
        check_eq("t5_unmapped", rd, 16'h0000);
        bus_read(4'd9, rd);
        check_eq("t5_past_counts", rd, 16'h0000);

        // T6: reset mid-operation.
        bus_write(4'd1, 16'hFFFF, rd);
        bus_read(4'd1, rd);
        check_eq("t6_mask_width", rd, 16'h000F);
        irq_in = 4'b0000; tick();
        irq_in = 4'b1111; tick();
        bus_read(4'd0, rd);
        check_eq("t6_pending_all", rd, 16'h000F);
        check_eq("t6_irq_high", {15'h0000, irq}, 16'h0001);
        reset = 1'b1; tick();
        check_eq("t6_irq_reset", {15'h0000, irq}, 16'h0000);
        check_eq("t6_rdata_reset", readdata, 16'h0000);
        reset = 1'b0; tick(); tick();
        for (int a = 0; a < 9; a++) begin
            if (a != 4) begin
                bus_read(4'(a), rd);
                check_eq($sformatf("t6_reg%0d_zero", a), rd, 16'h0000);
            end
        end
        check_eq("t6_irq_after", {15'h0000, irq}, 16'h0000);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
